// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch + data) in front of a
// shared single-port memory with variable-latency completion.
//
// Handshake: a requester raises req with its address/we/wdata and holds them
// stable until it sees its one-cycle ack; it may drop req or present a new
// transaction in the ack cycle. The arbiter samples requests only in IDLE,
// so the ack cycle (RESP) never overlaps a new grant decision.
// Memory side: mem_req_o is held with stable fields until mem_ack_i=1; the
// memory may ack in the very cycle mem_req_o rises.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // state_q is the observable FSM state for checkers
  state_t              state_q;
  state_t              state_d;
  logic                owner_q;   // 1 = data port owns the transaction, 0 = fetch
  logic [3:0]          starve_cnt;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                grant_d;
  logic                grant_if;

  // Grant decision: only in IDLE; data wins unless fetch has waited STARVE_MAX data grants
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE) begin
      if (if_req_i && (starve_cnt == STARVE_LIM)) begin
        grant_if = 1'b1;
      end else if (d_req_i) begin
        grant_d = 1'b1;
      end else if (if_req_i) begin
        grant_if = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; mem_ack_i matters only in BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_d || grant_if) state_d = BUSY;
      BUSY:    if (mem_ack_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ack pulses to the owner for the single RESP cycle; stalls are combinational
  always_comb begin
    if_ack_o   = (state_q == RESP) && !owner_q;
    d_ack_o    = (state_q == RESP) && owner_q;
    if_stall_o = if_req_i & ~if_ack_o;
    d_stall_o  = d_req_i & ~d_ack_o;
  end

  // Transaction latch and read-data capture; memory fields are held from grant to ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else if (grant_d) begin
      owner_q     <= 1'b1;
      mem_req_q   <= 1'b1;
      mem_we_q    <= d_we_i;
      mem_addr_q  <= d_addr_i;
      mem_wdata_q <= d_wdata_i;
    end else if (grant_if) begin
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= if_addr_i;
      mem_wdata_q <= '0;
    end else if ((state_q == BUSY) && mem_ack_i) begin
      mem_req_q <= 1'b0;
      if (owner_q) begin
        d_rdata_q <= mem_rdata_i;
      end else begin
        if_rdata_q <= mem_rdata_i;
      end
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting fetch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= 4'd0;
    end else if (grant_if) begin
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      if (!if_req_i) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule
